// File: rtl/wb_stage.sv
// wb_stage: MIPS write-back stage, single register-file write port.
// Handles ALU/link results and load extraction with sign extension.
module wb_stage #(
   parameter int DW       = 32,
   parameter int AW       = 5,
   parameter int LINK_REG = 31,
   parameter int LINK_OFS = 8,
   parameter int CNT_W    = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_regwrite,
   input  logic [AW-1:0]    in_rd,
   input  logic [DW-1:0]    in_alu,
   input  logic [DW-1:0]    in_pc,
   input  logic             in_is_link,
   input  logic             in_is_load,
   input  logic [1:0]       in_ld_size,
   input  logic             in_ld_uns,
   input  logic [1:0]       in_byte_off,
   input  logic             mem_rvalid,
   input  logic [DW-1:0]    mem_rdata,
   output logic             wb_we,
   output logic [AW-1:0]    wb_waddr,
   output logic [DW-1:0]    wb_wdata,
   output logic             wb_err,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   state_t        r_state;
   logic [AW-1:0] r_rd;
   logic          r_rw;
   logic [1:0]    r_size;
   logic          r_uns;
   logic [1:0]    r_off;

   logic          w_acc;
   logic          w_mis;
   logic [AW-1:0] w_dest;
   logic [DW-1:0] w_data;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [DW-1:0] w_ext;

   assign in_ready = (r_state == S_IDLE);
   assign w_acc    = in_valid & in_ready;
   assign w_dest   = in_is_link ? AW'(LINK_REG) : in_rd;
   assign w_data   = in_is_link ? in_pc + DW'(LINK_OFS) : in_alu;

   // Reserved sizes and unaligned half/word loads are rejected at accept
   always_comb begin
      w_mis = 1'b0;
      unique case (in_ld_size)
         2'b00:   w_mis = 1'b0;
         2'b01:   w_mis = in_byte_off[0];
         2'b10:   w_mis = (in_byte_off != 2'b00);
         default: w_mis = 1'b1;
      endcase
   end

   // Big-endian lane select and extension of the returning load word
   always_comb begin
      w_byte = 8'h00;
      w_ext  = mem_rdata;
      unique case (r_off)
         2'd0:    w_byte = mem_rdata[DW-1  -: 8];
         2'd1:    w_byte = mem_rdata[DW-9  -: 8];
         2'd2:    w_byte = mem_rdata[DW-17 -: 8];
         default: w_byte = mem_rdata[DW-25 -: 8];
      endcase
      w_half = r_off[1] ? mem_rdata[DW-17 -: 16]
                        : mem_rdata[DW-1 -: 16];
      unique case (r_size)
         2'b00:   w_ext = {{(DW-8){~r_uns & w_byte[7]}}, w_byte};
         2'b01:   w_ext = {{(DW-16){~r_uns & w_half[15]}}, w_half};
         default: w_ext = mem_rdata;
      endcase
   end

   // Control FSM with registered write-port, error and retire outputs
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state  <= S_IDLE;
         r_rd     <= '0;
         r_rw     <= 1'b0;
         r_size   <= 2'b00;
         r_uns    <= 1'b0;
         r_off    <= 2'b00;
         wb_we    <= 1'b0;
         wb_waddr <= '0;
         wb_wdata <= '0;
         wb_err   <= 1'b0;
         retired  <= '0;
      end else begin
         wb_we  <= 1'b0;
         wb_err <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_acc) begin
                  if (!in_is_load) begin
                     if (in_regwrite && (w_dest != '0)) begin
                        wb_we    <= 1'b1;
                        wb_waddr <= w_dest;
                        wb_wdata <= w_data;
                     end
                     retired <= retired + 1'b1;
                  end else if (w_mis) begin
                     wb_err <= 1'b1;
                  end else begin
                     r_rd    <= in_rd;
                     r_rw    <= in_regwrite;
                     r_size  <= in_ld_size;
                     r_uns   <= in_ld_uns;
                     r_off   <= in_byte_off;
                     r_state <= S_WAIT;
                  end
               end
            end
            default: begin
               if (mem_rvalid) begin
                  if (r_rw && (r_rd != '0)) begin
                     wb_we    <= 1'b1;
                     wb_waddr <= r_rd;
                     wb_wdata <= w_ext;
                  end
                  retired <= retired + 1'b1;
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed bench for the write-back stage.
// One task per scenario, hand-computed expectations.
module tb_wb_stage;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_regwrite = 1'b0;
   logic [4:0]  in_rd = '0;
   logic [31:0] in_alu = '0;
   logic [31:0] in_pc = '0;
   logic        in_is_link = 1'b0;
   logic        in_is_load = 1'b0;
   logic [1:0]  in_ld_size = '0;
   logic        in_ld_uns = 1'b0;
   logic [1:0]  in_byte_off = '0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        wb_we;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;
   logic        wb_err;
   logic [31:0] retired;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] exp_ret = 0;

   wb_stage dut (
      .CLK(CLK), .RST(RST),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_regwrite(in_regwrite), .in_rd(in_rd),
      .in_alu(in_alu), .in_pc(in_pc),
      .in_is_link(in_is_link), .in_is_load(in_is_load),
      .in_ld_size(in_ld_size), .in_ld_uns(in_ld_uns),
      .in_byte_off(in_byte_off),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .wb_we(wb_we), .wb_waddr(wb_waddr),
      .wb_wdata(wb_wdata), .wb_err(wb_err),
      .retired(retired)
   );

   always #5 CLK = ~CLK;

   task automatic issue(input logic rw, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] pc,
                        input logic link, input logic load,
                        input logic [1:0] sz, input logic uns,
                        input logic [1:0] off);
      @(negedge CLK);
      in_regwrite = rw; in_rd = rd; in_alu = alu; in_pc = pc;
      in_is_link = link; in_is_load = load; in_ld_size = sz;
      in_ld_uns = uns; in_byte_off = off; in_valid = 1'b1;
      @(posedge CLK);
      #1;
      in_valid = 1'b0; in_is_load = 1'b0; in_is_link = 1'b0;
   endtask

   task automatic mem_resp(input logic [31:0] d);
      @(negedge CLK);
      mem_rvalid = 1'b1; mem_rdata = d;
      @(posedge CLK);
      #1;
      mem_rvalid = 1'b0;
   endtask

   task automatic test_reset;
      #12;
      if ({wb_we, wb_err} !== 2'b00) begin
         n_err++; $display("FAIL reset_pulses got %b want 00", {wb_we, wb_err});
      end
      n_cmp++;
      if ({wb_waddr, wb_wdata} !== 37'd0) begin
         n_err++; $display("FAIL reset_wport got %h/%h want 0/0", wb_waddr, wb_wdata);
      end
      n_cmp++;
      if (retired !== 32'd0 || in_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_state got ret=%0d rdy=%b want 0/1", retired, in_ready);
      end
      n_cmp++;
      @(negedge CLK); RST = 1'b1;
   endtask

   task automatic test_add;
      issue(1, 5'd5, 32'h0000_1234, 32'h0, 0, 0, 2'b00, 0, 2'b00);
      exp_ret++;
      if (wb_we !== 1'b1 || wb_waddr !== 5'd5 || wb_wdata !== 32'h1234) begin
         n_err++; $display("FAIL add got we=%b a=%0d d=%h want 1/5/1234", wb_we, wb_waddr, wb_wdata);
      end
      n_cmp++;
      if (retired !== exp_ret) begin
         n_err++; $display("FAIL add_ret got %0d want %0d", retired, exp_ret);
      end
      n_cmp++;
      @(posedge CLK); #1;
      if (wb_we !== 1'b0 || wb_wdata !== 32'h1234) begin
         n_err++; $display("FAIL add_pulse got we=%b d=%h want 0/1234", wb_we, wb_wdata);
      end
      n_cmp++;
   endtask

   task automatic test_jal;
      issue(1, 5'd9, 32'h5555_5555, 32'h0040_0010, 1, 0, 2'b00, 0, 2'b00);
      exp_ret++;
      if (wb_we !== 1'b1 || wb_waddr !== 5'd31 || wb_wdata !== 32'h0040_0018) begin
         n_err++; $display("FAIL jal got we=%b a=%0d d=%h want 1/31/00400018", wb_we, wb_waddr, wb_wdata);
      end
      n_cmp++;
   endtask

   task automatic test_zero;
      issue(1, 5'd0, 32'hDEAD_BEEF, 32'h0, 0, 0, 2'b00, 0, 2'b00);
      exp_ret++;
      if (wb_we !== 1'b0 || retired !== exp_ret) begin
         n_err++; $display("FAIL zero got we=%b ret=%0d want 0/%0d", wb_we, retired, exp_ret);
      end
      n_cmp++;
      if (wb_waddr !== 5'd31 || wb_wdata !== 32'h0040_0018) begin
         n_err++; $display("FAIL zero_hold got %0d/%h want 31/00400018", wb_waddr, wb_wdata);
      end
      n_cmp++;
   endtask

   task automatic test_load(input string nm, input logic [4:0] rd,
                            input logic [1:0] sz, input logic uns,
                            input logic [1:0] off, input int waits,
                            input logic [31:0] rdata,
                            input logic [31:0] want);
      issue(1, rd, 32'h0, 32'h0, 0, 1, sz, uns, off);
      if (in_ready !== 1'b0 || wb_we !== 1'b0) begin
         n_err++; $display("FAIL %s_acc got rdy=%b we=%b want 0/0", nm, in_ready, wb_we);
      end
      n_cmp++;
      for (int i = 0; i < waits; i++) begin
         @(posedge CLK); #1;
         if (in_ready !== 1'b0 || wb_we !== 1'b0) begin
            n_err++; $display("FAIL %s_wait%0d got rdy=%b we=%b want 0/0", nm, i, in_ready, wb_we);
         end
         n_cmp++;
      end
      mem_resp(rdata);
      exp_ret++;
      if (wb_we !== 1'b1 || wb_waddr !== rd || wb_wdata !== want) begin
         n_err++; $display("FAIL %s got we=%b a=%0d d=%h want 1/%0d/%h", nm, wb_we, wb_waddr, wb_wdata, rd, want);
      end
      n_cmp++;
      if (retired !== exp_ret || in_ready !== 1'b1) begin
         n_err++; $display("FAIL %s_ret got %0d/%b want %0d/1", nm, retired, in_ready, exp_ret);
      end
      n_cmp++;
   endtask

   task automatic test_loads;
      test_load("lb", 5'd4, 2'b00, 0, 2'd1, 3, 32'h11F0_2233, 32'hFFFF_FFF0);
      test_load("lhu", 5'd6, 2'b01, 1, 2'd2, 1, 32'h11F0_2233, 32'h0000_2233);
      test_load("lh", 5'd3, 2'b01, 0, 2'd0, 0, 32'h8001_0000, 32'hFFFF_8001);
      test_load("lbu", 5'd8, 2'b00, 1, 2'd3, 2, 32'h0000_00F5, 32'h0000_00F5);
      test_load("lb0", 5'd10, 2'b00, 0, 2'd0, 0, 32'h7F80_0000, 32'h0000_007F);
      test_load("lw", 5'd12, 2'b10, 0, 2'd0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D);
   endtask

   task automatic test_misaligned;
      issue(1, 5'd7, 32'h0, 32'h0, 0, 1, 2'b10, 0, 2'd2);
      if (wb_err !== 1'b1 || wb_we !== 1'b0) begin
         n_err++; $display("FAIL lw_mis got err=%b we=%b want 1/0", wb_err, wb_we);
      end
      n_cmp++;
      if (retired !== exp_ret || in_ready !== 1'b1) begin
         n_err++; $display("FAIL lw_mis_st got %0d/%b want %0d/1", retired, in_ready, exp_ret);
      end
      n_cmp++;
      @(posedge CLK); #1;
      if (wb_err !== 1'b0) begin
         n_err++; $display("FAIL lw_mis_pulse got %b want 0", wb_err);
      end
      n_cmp++;
      issue(1, 5'd7, 32'h0, 32'h0, 0, 1, 2'b11, 0, 2'd0);
      if (wb_err !== 1'b1 || in_ready !== 1'b1) begin
         n_err++; $display("FAIL rsv got err=%b rdy=%b want 1/1", wb_err, in_ready);
      end
      n_cmp++;
   endtask

   task automatic test_back_to_back;
      @(negedge CLK);
      in_regwrite = 1; in_rd = 5'd1; in_alu = 32'hA; in_valid = 1;
      @(posedge CLK); #1;
      exp_ret++;
      if (wb_we !== 1'b1 || wb_waddr !== 5'd1 || wb_wdata !== 32'hA) begin
         n_err++; $display("FAIL b2b_a got %b/%0d/%h want 1/1/a", wb_we, wb_waddr, wb_wdata);
      end
      n_cmp++;
      @(negedge CLK);
      in_rd = 5'd2; in_alu = 32'hB;
      @(posedge CLK); #1;
      in_valid = 0;
      exp_ret++;
      if (wb_we !== 1'b1 || wb_waddr !== 5'd2 || wb_wdata !== 32'hB) begin
         n_err++; $display("FAIL b2b_b got %b/%0d/%h want 1/2/b", wb_we, wb_waddr, wb_wdata);
      end
      n_cmp++;
      if (retired !== exp_ret) begin
         n_err++; $display("FAIL b2b_ret got %0d want %0d", retired, exp_ret);
      end
      n_cmp++;
   endtask

   task automatic test_reset_mid;
      issue(1, 5'd7, 32'h0, 32'h0, 0, 1, 2'b10, 0, 2'd0);
      @(negedge CLK); RST = 1'b0;
      #1;
      exp_ret = 0;
      if ({wb_we, wb_err, wb_waddr, wb_wdata, retired} !== 71'd0 || in_ready !== 1'b1) begin
         n_err++; $display("FAIL rst_mid got we=%b a=%0d d=%h r=%0d rdy=%b want 0s/1", wb_we, wb_waddr, wb_wdata, retired, in_ready);
      end
      n_cmp++;
      @(negedge CLK); RST = 1'b1;
      mem_resp(32'h1234_5678);
      if (wb_we !== 1'b0 || retired !== 32'd0 || wb_wdata !== 32'd0) begin
         n_err++; $display("FAIL rst_mid_rv got we=%b r=%0d d=%h want 0/0/0", wb_we, retired, wb_wdata);
      end
      n_cmp++;
   endtask

   initial begin
      test_reset;
      test_add;
      test_jal;
      test_zero;
      test_loads;
      test_misaligned;
      test_back_to_back;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
